// File: rtl/decode_hazard_ctl_if.sv
// Pipeline-control bus between the decode-stage hazard controller and the datapath.
// The controller uses the slave modport. The datapath, or a bench standing in for it,
// uses the master modport.
interface decode_hazard_ctl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      IF_ID_instrout;
    logic             ID_EX_memread;
    logic [4:0]       ID_EX_rt;
    logic             EX_MEM_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             mem_timeout;

    modport master (
        output IF_ID_instrout, ID_EX_memread, ID_EX_rt, EX_MEM_branch_taken,
               mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en,
               state, stall_cnt, flush_cnt, mem_timeout
    );

    modport slave (
        input  IF_ID_instrout, ID_EX_memread, ID_EX_rt, EX_MEM_branch_taken,
               mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en,
               state, stall_cnt, flush_cnt, mem_timeout
    );
endinterface

// File: rtl/decode_hazard_ctl.sv
// Decode-stage sequencing controller for the 5-stage MIPS pipeline.
// It stalls on load-use hazards, freezes the pipe while data memory is busy,
// and flushes IF/ID after a taken branch.
// It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.
module decode_hazard_ctl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input logic                clk,
    input logic                rst_n,
    decode_hazard_ctl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    localparam int               WAIT_W     = 8;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic              mem_timeout_q;

    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              load_use;
    logic              mem_stall;
    logic              flush_event;
    logic              unused_instr_bits;

    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              pipe_en;

    assign id_rs             = bus.IF_ID_instrout[25:21];
    assign id_rt             = bus.IF_ID_instrout[20:16];
    assign unused_instr_bits = ^{bus.IF_ID_instrout[31:26], bus.IF_ID_instrout[15:0]};

    assign load_use  = bus.ID_EX_memread && (bus.ID_EX_rt != 5'd0) &&
                       ((bus.ID_EX_rt == id_rs) || (bus.ID_EX_rt == id_rt));
    assign mem_stall = bus.mem_req && !bus.mem_ready;

    assign flush_event = (state_q == ST_RUN) && !mem_stall && bus.EX_MEM_branch_taken;

    // Hold the sequencing state. Reset always lands in RUN, so a half-done flush is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pick the next state. A memory stall beats a branch flush. Load-use never leaves RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (bus.EX_MEM_branch_taken) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Drive the latch enables for this cycle. During reset they are forced to free-running RUN values.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_en      = 1'b1;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        pipe_en     = 1'b0;
                    end else if (bus.EX_MEM_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    pipe_en     = 1'b0;
                end
                ST_FLUSH: begin
                    if_id_flush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Count stall cycles and branch flushes. Both counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_event && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Measure how long memory has kept us waiting. The timeout flag stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else if (state_q == ST_MEM_WAIT) begin
            if (wait_cnt_q == WAIT_LIMIT - WAIT_W'(1)) begin
                mem_timeout_q <= 1'b1;
            end
            if (bus.mem_ready) begin
                wait_cnt_q <= '0;
            end else if (wait_cnt_q != WAIT_LIMIT) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            wait_cnt_q <= '0;
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_write  = if_id_write;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.pipe_en      = pipe_en;
    assign bus.state        = state_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
    assign bus.mem_timeout  = mem_timeout_q;

endmodule

// File: doc/decode_hazard_ctl.md
Name: decode_hazard_ctl

Overview:
Pipeline sequencing controller for the 5-stage MIPS datapath, sitting beside the instruction-decode stage and the IF/ID and ID/EX latches. It detects load-use hazards, freezes the pipeline while data memory is not ready, and flushes on taken branches. It drives PC-write, IF/ID-write, IF/ID-flush, ID/EX-bubble and global pipe-enable, and keeps stall statistics and a memory-timeout flag.

Parameters:
CNT_W, 16, width of the saturating stall/flush event counters
MEM_TIMEOUT, 8, max consecutive MEM_WAIT cycles before mem_timeout is set (1..2^8-1)

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
IF_ID_instrout  in  32  instruction in IF/ID; rs=[25:21], rt=[20:16], opcode=[31:26]
ID_EX_memread  in  1  instruction in ID/EX is a load (M control bit)
ID_EX_rt  in  5  destination rt of instruction in ID/EX
EX_MEM_branch_taken  in  1  branch in EX/MEM resolved taken
mem_req  in  1  data memory access active in MEM stage
mem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID latch enable
if_id_flush  out  1  IF/ID latch loads NOP (32'h0)
id_ex_bubble  out  1  ID/EX latch loads zero WB/M/EX controls
pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB latches
state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 FLUSH
stall_cnt  out  CNT_W  count of cycles with pc_write=0
flush_cnt  out  CNT_W  count of branch flushes
mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT cycles

Behaviour:
- Reset (rst_n=0, async): state=RUN, stall_cnt=0, flush_cnt=0, mem_timeout=0, wait counter=0. While in reset, outputs hold RUN-idle values: pc_write=1, if_id_write=1, pipe_en=1, flush/bubble=0.
- Load-use hazard (combinational): lu = ID_EX_memread && ID_EX_rt!=0 && (ID_EX_rt==rs || ID_EX_rt==rt).
- Priority per cycle: MEM_WAIT condition > branch flush > load-use.
- RUN:
  - mem_req && !mem_ready: the same cycle drives pc_write=0, if_id_write=0, pipe_en=0; next state MEM_WAIT.
  - else EX_MEM_branch_taken: the same cycle drives if_id_flush=1, id_ex_bubble=1, pc_write=1; next state FLUSH; flush_cnt++.
  - else lu: the same cycle drives pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_en=1; stays in RUN (one-cycle stall, since the bubble clears ID_EX_memread).
  - else all enables=1, flush/bubble=0.
- MEM_WAIT:
  - Full freeze: pc_write=0, if_id_write=0, pipe_en=0, no bubble/flush.
  - Wait counter increments each cycle. When it reaches MEM_TIMEOUT, mem_timeout is set (sticky until reset); the FSM keeps waiting.
  - mem_ready=1: this cycle still frozen; next state RUN; wait counter cleared.
  - Branch/load-use inputs are ignored while in MEM_WAIT and re-evaluated in RUN.
- FLUSH: one cycle.
  - if_id_flush=1, all enables=1; next state RUN.
  - If mem_req && !mem_ready arrives in FLUSH, go to MEM_WAIT instead; the flush still completes this cycle.
- stall_cnt increments on every cycle with pc_write=0 (after reset) and saturates at 2^CNT_W-1. flush_cnt saturates the same way.
- rst_n deasserted mid-MEM_WAIT or mid-FLUSH returns to RUN immediately; no pending flush is replayed.

Test Plan:
- Load-use: ID_EX_memread=1, ID_EX_rt=5, instr rs=5 (32'h00A52020) -> exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1.
- rt=0 guard: ID_EX_memread=1, ID_EX_rt=0, instr rs=0 -> no stall; pc_write stays 1.
- Branch flush: EX_MEM_branch_taken pulse 1 cycle -> if_id_flush=1 for 2 cycles (RUN detect + FLUSH), id_ex_bubble=1 on the first, flush_cnt=1.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> pipe_en=0 for 4 cycles, state 1 then 0, stall_cnt=4, mem_timeout=0.
- Timeout: mem_ready low 10 cycles with MEM_TIMEOUT=8 -> mem_timeout=1 after the 8th wait cycle, still 1 after return to RUN.
- Simultaneous events and reset: branch_taken+lu+mem stall together -> MEM_WAIT wins, flush_cnt unchanged. Then rst_n=0 mid-wait -> state=0, all counters 0, pc_write=1 asynchronously.
